// File: rtl/fir_pkg.sv
// Shared FIR package: default widths, tap-window state encoding and the
// accumulator width shared with the MAC stage.
package fir_pkg;

  localparam int FIR_DATA_WIDTH = 13;
  localparam int FIR_TAPS       = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } tapwin_state_t;

  // Full-precision sum of TAPS products of two DATA_WIDTH signed operands.
  function automatic int acc_width(input int dw, input int taps);
    return 2 * dw + $clog2(taps);
  endfunction

  localparam int ACC_WIDTH = acc_width(FIR_DATA_WIDTH, FIR_TAPS);

endpackage

// File: rtl/fir_coef_bank.sv
// Run-time-writable coefficient register file. Out-of-range addresses
// (possible when TAPS is not a power of two) are dropped.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int TAPS       = FIR_TAPS
) (
  input  logic                                  CLK,
  input  logic                                  RST_n,
  input  logic                                  COEF_WE,
  input  logic [$clog2(TAPS)-1:0]               COEF_ADDR,
  input  logic [DATA_WIDTH-1:0]                 COEF_DATA,
  output logic [TAPS-1:0][DATA_WIDTH-1:0]       H
);

  localparam int AW = $clog2(TAPS);

  logic in_range;

  // Address range check shared by every entry.
  always_comb begin
    in_range = (int'(COEF_ADDR) < TAPS);
  end

  for (genvar i = 0; i < TAPS; i++) begin : g_coef
    logic wr;
    assign wr = COEF_WE && in_range && (COEF_ADDR == AW'(i));

    // One coefficient register; unaffected by FLUSH.
    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n)  H[i] <= '0;
      else if (wr) H[i] <= COEF_DATA;
    end
  end

endmodule

// File: rtl/fir_tap_window.sv
// FIR input stage: TAPS-deep sample delay line, fill tracking state machine,
// VWIN window-ready pulse and the coefficient bank.
// Optional macro TAPWIN_ZERO_FILL_EN: treat the line as pre-filled with zeros,
// so every accept produces VWIN (FILL_CNT still reports the real count).
module fir_tap_window
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int TAPS       = FIR_TAPS
) (
  input  logic                                  CLK,
  input  logic                                  RST_n,
  input  logic [DATA_WIDTH-1:0]                 DIN,
  input  logic                                  VIN,
  input  logic                                  FLUSH,
  input  logic                                  COEF_WE,
  input  logic [$clog2(TAPS)-1:0]               COEF_ADDR,
  input  logic [DATA_WIDTH-1:0]                 COEF_DATA,
  output logic [TAPS-1:0][DATA_WIDTH-1:0]       tp_w,
  output logic [TAPS-1:0][DATA_WIDTH-1:0]       H,
  output logic                                  VWIN,
  output logic [$clog2(TAPS+1)-1:0]             FILL_CNT
);

  localparam int CW = $clog2(TAPS + 1);

  tapwin_state_t state, state_nxt;
  logic          accept;
  logic          last_fill;
  logic          win_set;

  // FLUSH beats VIN: a colliding sample is dropped.
  assign accept    = VIN && !FLUSH;
  assign last_fill = (FILL_CNT == CW'(TAPS - 1));

  // Delay line: newest sample enters at index 0.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)      tp_w <= '0;
    else if (FLUSH)  tp_w <= '0;
    else if (accept) tp_w <= {tp_w[TAPS-2:0], DIN};
  end

  // Fill counter, saturating at TAPS.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)                                   FILL_CNT <= '0;
    else if (FLUSH)                               FILL_CNT <= '0;
    else if (accept && FILL_CNT != CW'(TAPS))     FILL_CNT <= FILL_CNT + 1'b1;
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (FLUSH) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state_nxt = FILL;
        FILL:    if (accept && last_fill) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Output decode: does this accept complete a full window?
  always_comb begin
    win_set = 1'b0;
`ifdef TAPWIN_ZERO_FILL_EN
    win_set = accept;
`else
    case (state)
      FILL:    win_set = accept && last_fill;
      RUN:     win_set = accept;
      default: win_set = 1'b0;
    endcase
`endif
  end

  // VWIN is registered so it lines up with the updated window.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) VWIN <= 1'b0;
    else        VWIN <= win_set;
  end

  fir_coef_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAPS       (TAPS)
  ) u_coef (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .COEF_WE   (COEF_WE),
    .COEF_ADDR (COEF_ADDR),
    .COEF_DATA (COEF_DATA),
    .H         (H)
  );

endmodule

// File: doc/fir_tap_window.md
# fir_tap_window

Input stage of the FIR datapath. It accepts one signed sample per valid cycle into a TAPS-deep delay line. It presents the full tap window `tp_w` together with the coefficient bank `H` to the downstream MAC unit, and pulses `VWIN` when a new window is ready. It also owns the run-time-writable coefficient register bank. No backpressure is needed, because the MAC consumes a window every cycle.

## Interface
- `DATA_WIDTH`, 13: sample and coefficient width, signed.
- `TAPS`, 8: delay-line depth and number of coefficients; must be ≥ 2.
- `CLK` in 1: single clock, rising edge.
- `RST_n` in 1: reset, asynchronous, active-low.
- `DIN` in DATA_WIDTH: signed input sample.
- `VIN` in 1: `DIN` valid; the sample is accepted on every cycle `VIN`=1.
- `FLUSH` in 1: synchronous clear of the delay line and fill state.
- `COEF_WE` in 1: coefficient write enable.
- `COEF_ADDR` in $clog2(TAPS): coefficient index.
- `COEF_DATA` in DATA_WIDTH: signed coefficient value.
- `tp_w` out DATA_WIDTH×[0:TAPS-1]: window; `tp_w[0]` is the newest sample.
- `H` out DATA_WIDTH×[0:TAPS-1]: coefficient bank.
- `VWIN` out 1: one-cycle pulse meaning `tp_w` holds a new valid window.
- `FILL_CNT` out $clog2(TAPS+1): samples held, saturating at TAPS.

## Operation
- **Reset:** `tp_w`, `H`, `VWIN` and `FILL_CNT` all go to 0, and the state goes to EMPTY. The clear is immediate (asynchronous), including in the middle of a fill or run.
- **Shift on accept:** when `VIN`=1, `tp_w[0]` takes `DIN` and each `tp_w[i]` takes `tp_w[i-1]`. `FILL_CNT` increments, saturating at TAPS.
- **Hold:** when `VIN`=0, `tp_w` and `FILL_CNT` hold and `VWIN` is 0.
- **State machine:**
  - EMPTY: `FILL_CNT`=0. An accepted sample moves to FILL.
  - FILL: 0<`FILL_CNT`<TAPS. An accept that brings the count to TAPS moves to RUN.
  - RUN: `FILL_CNT`=TAPS. Stays in RUN.
  - `FLUSH` in any state moves to EMPTY.
- **`VWIN` generation:** `VWIN`=1 the cycle after any accept whose post-shift count equals TAPS. This covers the accept that enters RUN and every accept while in RUN.
- **`FLUSH` behaviour:**
  - Zeroes `tp_w` and `FILL_CNT`, and forces `VWIN` to 0 on the next cycle.
  - If `FLUSH` and `VIN` are both high, `FLUSH` wins and the sample is dropped.
  - `H` is not affected by `FLUSH`.
- **Coefficient writes:**
  - `COEF_WE`=1 writes `COEF_DATA` to `H[COEF_ADDR]`, visible the next cycle.
  - A `COEF_ADDR` ≥ TAPS is ignored.
  - Writes are independent of `VIN` and `FLUSH`; all may occur in the same cycle.
- **Arithmetic:** none. Sample and coefficient values pass through bit-exact with no sign extension or truncation.

## Timing
- Latency: an accept at cycle n gives updated `tp_w` and `VWIN` at cycle n+1. Both are registered.
- Throughput: one window per cycle when `VIN` is held high in RUN.
- First `VWIN` after EMPTY: the cycle after the TAPS-th accepted sample.
- `VWIN` is never high for two consecutive cycles unless `VIN` was high on both preceding cycles.
- Deasserting `RST_n` releases the block to EMPTY; the first accept can occur on the following edge.

## Configuration
- Macro `TAPWIN_ZERO_FILL_EN`:
  - Defined: the delay line is treated as pre-filled with zeros. Every accept, including those in EMPTY and FILL, produces `VWIN` the next cycle. `FILL_CNT` still reports the real count.
  - Not defined: `VWIN` is suppressed until `FILL_CNT` reaches TAPS, as described above.

## Structure
- Shared package `fir_pkg` holds:
  - default `DATA_WIDTH` and `TAPS`;
  - the `tapwin_state_t` enum (EMPTY, FILL, RUN);
  - the `ACC_WIDTH` expression shared with the MAC.
- Sub-module `fir_coef_bank` holds the `H` register file, the write decode and the address range check.
- The top level contains the delay line, the state machine, the fill counter and `VWIN` generation.

## Test plan
- **Reset:** with `RST_n` low mid-stream, `tp_w`, `H`, `VWIN` and `FILL_CNT` read 0 immediately and the state is EMPTY.
- **Fill and first window:** DIN=1..8 on consecutive cycles with `VIN`=1. `VWIN` stays 0 through the 7th sample and goes to 1 the cycle after the 8th. `tp_w` = {8,7,6,5,4,3,2,1}.
- **Run and gap:** in RUN, DIN=9 gives `tp_w`={9,8,...,2} and a `VWIN` pulse. Then two cycles of `VIN`=0 give `VWIN`=0 with `tp_w` held.
- **Flush collision:** `FLUSH`=1 and `VIN`=1 with DIN=-4096 in RUN.
  - Next cycle: `tp_w` all 0, `FILL_CNT`=0, `VWIN`=0.
  - The following 7 accepts produce no `VWIN`.
- **Coefficient writes, TAPS=6:**
  - Writing -5 to address 3 shows `H[3]`=-5 the next cycle.
  - A write to address 7 leaves `H` unchanged.
  - A write in the same cycle as an accept does not disturb the shift.
- **`TAPWIN_ZERO_FILL_EN` defined:** the first sample 100 after reset gives `VWIN`=1 next cycle, `tp_w`={100,0,0,0,0,0,0,0} and `FILL_CNT`=1.
